uart_char_tx: RTL and testbench

Serialises screen-write requests into the 4-byte UART command frame consumed by the VGA text console's receive path: column, row, ASCII code, newline. The block sits on the host/test side of the serial link. It turns one (col, row, char) request into a correctly ordered 8N1 byte stream. Out-of-range coordinates are rejected locally so they never desynchronise the console's frame counter.

---
 rtl/uart_char_tx.sv | 203 ++++++++++++++++++++
 tb/tb_uart_char_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_char_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_char_tx
// Description : Turns one (col, row, char) screen-write request into the
//               4-byte UART command frame {col, row, char, 8'h0A} for the
//               VGA text console. Requests with out-of-range coordinates are
//               dropped locally and flagged on err_o, so they can never put
//               the console's frame counter out of step.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   N_COL        : number of valid columns
//   N_ROW        : number of valid rows
// Ports:
//   clk_i        in   1  clock, rising edge
//   rstn_i       in   1  asynchronous active-low reset
//   req_valid_i  in   1  write request valid
//   req_ready_o  out  1  idle, a request can be accepted
//   col_i        in   7  target column
//   row_i        in   5  target row
//   char_i       in   7  ASCII code
//   tx_o         out  1  UART serial line (registered, idles high)
//   busy_o       out  1  frame in progress
//   err_o        out  1  one-cycle pulse on a rejected request
// Build option:
//   UART_TX_PARITY_EN : when defined, an even-parity bit is sent between the
//                       data bits and the stop bit (11 bits per byte).
// ============================================================================
module uart_char_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int N_COL        = 80,
  parameter int N_ROW        = 30
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [6:0] col_i,
  input  logic [4:0] row_i,
  input  logic [6:0] char_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

  // Range limits widened by one bit so N_COL = 128 / N_ROW = 32 stay meaningful.
  localparam logic [7:0] c_N_COL = 8'(N_COL);
  localparam logic [5:0] c_N_ROW = 6'(N_ROW);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd3;
`endif
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [c_BAUD_W-1:0] r_baud;
  logic [c_BAUD_W-1:0] w_baud_nxt;
  logic [2:0]          r_bit_idx;
  logic [2:0]          w_bit_idx_nxt;
  logic [1:0]          r_byte_idx;
  logic [1:0]          w_byte_idx_nxt;

  logic [6:0]          r_col;
  logic [4:0]          r_row;
  logic [6:0]          r_char;
  logic                r_tx;
  logic                r_err;

  logic                w_accept;
  logic                w_in_range;
  logic                w_bit_done;
  logic [7:0]          w_byte_nxt;
  logic                w_tx_nxt;

  assign w_accept   = req_valid_i && (r_state == c_IDLE);
  assign w_in_range = ({1'b0, col_i} < c_N_COL) && ({1'b0, row_i} < c_N_ROW);
  assign w_bit_done = (r_baud == c_BAUD_LAST);

  // --------------------------------------------------------------------------
  // State register, counters, captured request and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= c_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_char     <= '0;
      r_tx       <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_err      <= w_accept && !w_in_range;
      if (w_accept && w_in_range) begin
        r_col  <= col_i;
        r_row  <= row_i;
        r_char <= char_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = r_baud;
    w_bit_idx_nxt  = r_bit_idx;
    w_byte_idx_nxt = r_byte_idx;

    case (r_state)
      c_IDLE: begin
        if (w_accept && w_in_range) w_state_nxt = c_START;
      end
      c_START: begin
        if (w_bit_done) w_state_nxt = c_DATA;
      end
      c_DATA: begin
        if (w_bit_done) begin
          // 3-bit index wraps 7 -> 0, ready for the next byte
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = c_PARITY;
`else
            w_state_nxt = c_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      c_PARITY: begin
        if (w_bit_done) w_state_nxt = c_STOP;
      end
`endif
      c_STOP: begin
        if (w_bit_done) begin
          if (r_byte_idx != 2'd3) begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_state_nxt    = c_START;
          end else begin
            w_state_nxt = c_IDLE;
          end
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase

    // Bit timer free-runs across byte boundaries so bytes abut with no gap;
    // everything is cleared whenever the FSM lands in IDLE.
    if (w_state_nxt == c_IDLE) begin
      w_baud_nxt     = '0;
      w_bit_idx_nxt  = '0;
      w_byte_idx_nxt = '0;
    end else if (r_state != c_IDLE) begin
      w_baud_nxt = w_bit_done ? '0 : r_baud + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic. tx is computed from the *next* state so the registered
  // line already shows the start bit in the cycle after acceptance.
  // --------------------------------------------------------------------------
  always_comb begin
    case (w_byte_idx_nxt)
      2'd0:    w_byte_nxt = {1'b0, r_col};
      2'd1:    w_byte_nxt = {3'b000, r_row};
      2'd2:    w_byte_nxt = {1'b0, r_char};
      default: w_byte_nxt = 8'h0A;
    endcase

    case (w_state_nxt)
      c_START:  w_tx_nxt = 1'b0;
      c_DATA:   w_tx_nxt = w_byte_nxt[w_bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
      c_PARITY: w_tx_nxt = ^w_byte_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase

    req_ready_o = (r_state == c_IDLE);
    busy_o      = (r_state != c_IDLE);
    tx_o        = r_tx;
    err_o       = r_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_char_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_char_tx
// Description : Self-checking bench for uart_char_tx. A reference model
//               expands each request into the expected serial bit list and
//               the line is compared every clock for the whole frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_char_tx;

  localparam int CPB   = 4;
  localparam int N_COL = 80;
  localparam int N_ROW = 30;
`ifdef UART_TX_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
`else
  localparam int BITS_PER_BYTE = 10;
`endif
  localparam int FRAME_CYC = 4 * BITS_PER_BYTE * CPB;

  logic       clk_i       = 1'b0;
  logic       rstn_i      = 1'b1;
  logic       req_valid_i = 1'b0;
  logic [6:0] col_i       = '0;
  logic [4:0] row_i       = '0;
  logic [6:0] char_i      = '0;
  logic       req_ready_o;
  logic       tx_o;
  logic       busy_o;
  logic       err_o;

  int n_checks = 0;
  int n_fail   = 0;

  bit exp_bits[$];

  always #5 clk_i = ~clk_i;

  uart_char_tx #(
    .CLKS_PER_BIT(CPB),
    .N_COL       (N_COL),
    .N_ROW       (N_ROW)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .col_i      (col_i),
    .row_i      (row_i),
    .char_i     (char_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  // Reference model: list of line levels, one entry per bit period.
  function automatic void build_frame(input logic [6:0] c, input logic [4:0] r,
                                      input logic [6:0] ch);
    logic [7:0] frame_bytes [4];
    frame_bytes[0] = {1'b0, c};
    frame_bytes[1] = {3'b000, r};
    frame_bytes[2] = {1'b0, ch};
    frame_bytes[3] = 8'h0A;
    exp_bits.delete();
    for (int b = 0; b < 4; b++) begin
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(frame_bytes[b][i]);
`ifdef UART_TX_PARITY_EN
      exp_bits.push_back(^frame_bytes[b]);
`endif
      exp_bits.push_back(1'b1);
    end
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request in the current cycle and checks the full frame.
  // Returns positioned in the first idle cycle after the final stop bit.
  task automatic run_frame(input logic [6:0] c, input logic [4:0] r, input logic [6:0] ch,
                           input bit hold, input logic [6:0] c2, input logic [4:0] r2,
                           input logic [6:0] ch2, input string name);
    int busy_cnt;
    bit ready_seen;
    bit err_seen;
    build_frame(c, r, ch);
    req_valid_i = 1'b1;
    col_i  = c;
    row_i  = r;
    char_i = ch;
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_accept: got %b expected 1", name, req_ready_o);
    end
    step();
    if (hold) begin
      col_i  = c2;
      row_i  = r2;
      char_i = ch2;
    end else begin
      req_valid_i = 1'b0;
      col_i  = 7'($urandom);
      row_i  = 5'($urandom);
      char_i = 7'($urandom);
    end
    busy_cnt   = 0;
    ready_seen = 1'b0;
    err_seen   = 1'b0;
    for (int t = 0; t < FRAME_CYC; t++) begin
      n_checks++;
      if (tx_o !== exp_bits[t / CPB]) begin
        n_fail++;
        $display("FAIL %s tx cycle %0d (bit %0d): got %b expected %b",
                 name, t, t / CPB, tx_o, exp_bits[t / CPB]);
      end
      if (busy_o === 1'b1) busy_cnt++;
      if (req_ready_o !== 1'b0) ready_seen = 1'b1;
      if (err_o !== 1'b0) err_seen = 1'b1;
      step();
    end
    n_checks++;
    if (busy_cnt != FRAME_CYC) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, FRAME_CYC);
    end
    n_checks++;
    if (ready_seen || err_seen) begin
      n_fail++;
      $display("FAIL %s ready/err during frame: ready_high=%b err_high=%b expected 0/0",
               name, ready_seen, err_seen);
    end
    n_checks++;
    if (busy_o !== 1'b0 || req_ready_o !== 1'b1 || tx_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end_of_frame: busy=%b ready=%b tx=%b expected 0 1 1",
               name, busy_o, req_ready_o, tx_o);
    end
  endtask

  task automatic test_reset();
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if (tx_o !== 1'b1 || req_ready_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: tx=%b ready=%b busy=%b err=%b expected 1 1 0 0",
               tx_o, req_ready_o, busy_o, err_o);
    end
    repeat (3) @(posedge clk_i);
    #3 rstn_i = 1'b1;
    step();
    n_checks++;
    if (tx_o !== 1'b1 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idle: tx=%b ready=%b busy=%b expected 1 1 0",
               tx_o, req_ready_o, busy_o);
    end
  endtask

  task automatic test_basic();
    run_frame(7'd5, 5'd3, 7'h41, 1'b0, '0, '0, '0, "basic");
`ifdef UART_TX_PARITY_EN
    step();
    run_frame(7'd5, 5'd3, 7'h43, 1'b0, '0, '0, '0, "parity");
`endif
  endtask

  task automatic reject_one(input logic [6:0] c, input logic [4:0] r, input string name);
    req_valid_i = 1'b1;
    col_i  = c;
    row_i  = r;
    char_i = 7'($urandom);
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (err_o !== 1'b1 || tx_o !== 1'b1 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s reject_pulse: err=%b tx=%b busy=%b ready=%b expected 1 1 0 1",
               name, err_o, tx_o, busy_o, req_ready_o);
    end
    step();
    n_checks++;
    if (err_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reject_after: err=%b tx=%b busy=%b expected 0 1 0",
               name, err_o, tx_o, busy_o);
    end
  endtask

  task automatic test_reject();
    reject_one(7'd80, 5'd0, "reject_col80");
    for (int k = 0; k < 4; k++) begin
      if (k[0])
        reject_one(7'($urandom_range(79, 0)), 5'($urandom_range(31, 30)), "reject_row");
      else
        reject_one(7'($urandom_range(127, 80)), 5'($urandom_range(29, 0)), "reject_col");
    end
    run_frame(7'd79, 5'd29, 7'($urandom), 1'b0, '0, '0, '0, "max_in_range");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      step();
      run_frame(7'($urandom_range(N_COL - 1, 0)), 5'($urandom_range(N_ROW - 1, 0)),
                7'($urandom), 1'b0, '0, '0, '0, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] c2;
    logic [4:0] r2;
    logic [6:0] ch2;
    c2  = 7'($urandom_range(N_COL - 1, 0));
    r2  = 5'($urandom_range(N_ROW - 1, 0));
    ch2 = 7'($urandom);
    step();
    run_frame(7'($urandom_range(N_COL - 1, 0)), 5'($urandom_range(N_ROW - 1, 0)),
              7'($urandom), 1'b1, c2, r2, ch2, "b2b_first");
    // No step here: valid is still high, so frame 2 is accepted in this cycle.
    run_frame(c2, r2, ch2, 1'b0, '0, '0, '0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    step();
    req_valid_i = 1'b1;
    col_i  = 7'($urandom_range(N_COL - 1, 0));
    row_i  = 5'd0;
    char_i = 7'($urandom);
    step();
    req_valid_i = 1'b0;
    // Land inside the data bits of the row byte (bits 11..18), all zero.
    repeat (13 * CPB + 2) step();
    n_checks++;
    if (tx_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: tx=%b busy=%b expected 0 1", tx_o, busy_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    n_checks++;
    if (tx_o !== 1'b1 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: tx=%b ready=%b busy=%b expected 1 1 0",
               tx_o, req_ready_o, busy_o);
    end
    #2 rstn_i = 1'b1;
    step();
    run_frame(7'($urandom_range(N_COL - 1, 0)), 5'($urandom_range(N_ROW - 1, 0)),
              7'($urandom), 1'b0, '0, '0, '0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
